// File: rtl/btn_pkg.sv
// Shared defaults and width helper for the push-button conditioner.
package btn_pkg;

   localparam int DEF_TICK_DIV     = 1000;
   localparam int DEF_SAMPLES      = 8;
   localparam int DEF_LONG_TICKS   = 50000;
   localparam int DEF_REPEAT_TICKS = 10000;

   // Counter width able to hold values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, tick-sampled shift register with hysteresis,
// edge pulses and hold counter for long-press / auto-repeat events.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int SAMPLES      = DEF_SAMPLES,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_i,
   input  logic pin_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic repeat_o
);

   localparam int HC_W = cnt_width(LONG_TICKS + REPEAT_TICKS + 1);
   localparam logic [HC_W-1:0] HC_LONG    = HC_W'(LONG_TICKS);
   localparam logic [HC_W-1:0] HC_LONG_M1 = HC_W'(LONG_TICKS - 1);
   localparam logic [HC_W-1:0] HC_RPT_M1  = HC_W'(LONG_TICKS + REPEAT_TICKS - 1);

   logic [1:0]         sync_q;
   logic [SAMPLES-1:0] sh_q, sh_d;
   logic               level_q, level_d;
   logic               level_prev_q;
   logic [HC_W-1:0]    hc_q, hc_d;
   logic               long_q, long_d;
   logic               repeat_q, repeat_d;

   always_comb begin
      sh_d = tick_i ? {sync_q[1], sh_q[SAMPLES-1:1]} : sh_q;

      level_d = level_q;
      if (&sh_q)
         level_d = 1'b1;
      else if (~|sh_q)
         level_d = 1'b0;

      hc_d     = hc_q;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      if (!level_q) begin
         hc_d = '0;
      end else if (tick_i) begin
         // Repeat period wraps back to LONG so pulses continue for as long as the hold lasts.
         if ((REPEAT_TICKS > 0) && (hc_q == HC_RPT_M1)) begin
            hc_d     = HC_LONG;
            repeat_d = 1'b1;
         end else if ((REPEAT_TICKS > 0) || (hc_q != HC_LONG)) begin
            hc_d   = hc_q + HC_W'(1);
            long_d = (hc_q == HC_LONG_M1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= '0;
         sh_q         <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         hc_q         <= '0;
         long_q       <= 1'b0;
         repeat_q     <= 1'b0;
      end else begin
         sync_q       <= {sync_q[0], pin_i};
         sh_q         <= sh_d;
         level_q      <= level_d;
         level_prev_q <= level_q;
         hc_q         <= hc_d;
         long_q       <= long_d;
         repeat_q     <= repeat_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = level_q & ~level_prev_q;
   assign release_o = ~level_q & level_prev_q;
   assign long_o    = long_q;
   assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: one shared sample-tick prescaler feeding
// an independent debounce/event channel per button.
module btn_debounce_multi
   import btn_pkg::*;
#(
   parameter int              N_CH         = 4,
   parameter int              TICK_DIV     = DEF_TICK_DIV,
   parameter int              SAMPLES      = DEF_SAMPLES,
   parameter int              LONG_TICKS   = DEF_LONG_TICKS,
   parameter int              REPEAT_TICKS = DEF_REPEAT_TICKS,
   parameter logic [N_CH-1:0] INVERT       = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] i_btn,
   output logic [N_CH-1:0] o_level,
   output logic [N_CH-1:0] o_press,
   output logic [N_CH-1:0] o_release,
   output logic [N_CH-1:0] o_long,
   output logic [N_CH-1:0] o_repeat
);

   localparam int CNT_W = cnt_width(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;

   assign tick  = (cnt_q == CNT_MAX);
   assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      btn_debounce_ch #(
         .SAMPLES      (SAMPLES),
         .LONG_TICKS   (LONG_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .tick_i    (tick),
         .pin_i     (i_btn[g] ^ INVERT[g]),
         .level_o   (o_level[g]),
         .press_o   (o_press[g]),
         .release_o (o_release[g]),
         .long_o    (o_long[g]),
         .repeat_o  (o_repeat[g])
      );
   end

endmodule
